audio_frontend_mc: RTL and testbench

- Parametrised multi-channel microphone front end: per-channel DC-offset calibration, saturating offset removal, and a boxcar-average decimator.
- Sits between the mic deserialiser and downstream DSP, in the audio_clk domain.
- Successor to the single-channel fixed-offset path. Adds N channels, re-triggerable calibration, saturation, and in-block decimation by 2^DECIM_LOG2.

---
 rtl/audio_frontend_mc_if.sv | 22 ++
 rtl/audio_frontend_mc.sv | 96 +++++++++
 tb/tb_audio_frontend_mc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/audio_frontend_mc_if.sv
// audio_frontend_mc_if: sample, control and result bundle between the mic deserialiser side and audio_frontend_mc
interface audio_frontend_mc_if #(
  parameter int WIDTH = 16,
  parameter int NUM_CH = 2
);
  logic offset_trigger;
  logic mic_data_valid;
  logic [NUM_CH*WIDTH-1:0] audio_in;
  logic [NUM_CH*WIDTH-1:0] processed_audio;
  logic processed_valid;
  logic [NUM_CH*WIDTH-1:0] offset_out;
  logic offset_valid;
  logic cal_busy;
  modport master (
    output offset_trigger, mic_data_valid, audio_in,
    input processed_audio, processed_valid, offset_out, offset_valid, cal_busy
  );
  modport slave (
    input offset_trigger, mic_data_valid, audio_in,
    output processed_audio, processed_valid, offset_out, offset_valid, cal_busy
  );
endinterface

// File: rtl/audio_frontend_mc.sv
// audio_frontend_mc: per-channel DC calibration, saturating offset removal and boxcar decimation; define AUDIO_FRONTEND_DC_TRACK_EN for leaky offset tracking in RUN
module audio_frontend_mc #(
  parameter int WIDTH = 16,
  parameter int NUM_CH = 2,
  parameter int CAL_LOG2 = 10,
  parameter int DECIM_LOG2 = 1,
  parameter int TRACK_SHIFT = 12
) (
  input logic audio_clk,
  input logic rst_in,
  audio_frontend_mc_if.slave b
);
  localparam int CW = WIDTH + CAL_LOG2;
  localparam int AW = WIDTH + DECIM_LOG2;
  localparam int DW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
  localparam logic [DW-1:0] DLAST = DW'((1 << DECIM_LOG2) - 1);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
  state_t state, state_n;
  logic [CAL_LOG2-1:0] cal_cnt;
  logic [DW-1:0] d_cnt;
  logic c_valid, cal_en, cal_done, d_wrap;
  logic signed [CW-1:0] cal_acc [NUM_CH];
  logic signed [CW-1:0] cal_sum [NUM_CH];
  logic signed [AW-1:0] dec_acc [NUM_CH];
  logic signed [AW-1:0] dec_sum [NUM_CH];
  logic signed [WIDTH:0] diff [NUM_CH];
  logic signed [WIDTH-1:0] smp [NUM_CH];
  logic signed [WIDTH-1:0] off [NUM_CH];
  logic signed [WIDTH-1:0] corr_n [NUM_CH];
  logic signed [WIDTH-1:0] corr [NUM_CH];
  logic signed [WIDTH-1:0] cal_off [NUM_CH];
  logic signed [WIDTH-1:0] avg [NUM_CH];
`ifdef AUDIO_FRONTEND_DC_TRACK_EN
  logic signed [WIDTH:0] trk [NUM_CH];
`endif
  assign cal_en = state == CAL && b.mic_data_valid && !b.offset_trigger;
  assign cal_done = cal_en && &cal_cnt;
  assign d_wrap = d_cnt == DLAST;
  assign b.cal_busy = state == CAL;
  always_ff @(posedge audio_clk) state <= rst_in ? IDLE : state_n;
  always_comb begin
    state_n = b.offset_trigger ? CAL : cal_done ? RUN : state;
    for (int i = 0; i < NUM_CH; i++) begin
      smp[i] = b.audio_in[i*WIDTH +: WIDTH];
      off[i] = b.offset_out[i*WIDTH +: WIDTH];
      diff[i] = (WIDTH+1)'(smp[i]) - (WIDTH+1)'(off[i]);
      corr_n[i] = !b.offset_valid ? smp[i] :
                  diff[i][WIDTH] != diff[i][WIDTH-1] ? (diff[i][WIDTH] ? SMIN : SMAX) : diff[i][WIDTH-1:0];
      cal_sum[i] = cal_acc[i] + CW'(smp[i]);
      cal_off[i] = WIDTH'(cal_sum[i] >>> CAL_LOG2);
      dec_sum[i] = dec_acc[i] + AW'(corr[i]);
      avg[i] = WIDTH'(dec_sum[i] >>> DECIM_LOG2);
`ifdef AUDIO_FRONTEND_DC_TRACK_EN
      trk[i] = (WIDTH+1)'(off[i]) + (diff[i] >>> TRACK_SHIFT);
`endif
    end
  end
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      cal_cnt <= '0;
      d_cnt <= '0;
      c_valid <= 1'b0;
      b.offset_valid <= 1'b0;
      b.processed_valid <= 1'b0;
      b.offset_out <= '0;
      b.processed_audio <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cal_acc[i] <= '0;
        dec_acc[i] <= '0;
        corr[i] <= '0;
      end
    end else begin
      c_valid <= b.mic_data_valid;
      b.processed_valid <= c_valid && d_wrap;
      if (b.offset_trigger || cal_done) cal_cnt <= '0;
      else if (cal_en) cal_cnt <= cal_cnt + CAL_LOG2'(1);
      if (c_valid) d_cnt <= d_wrap ? '0 : d_cnt + DW'(1);
      if (cal_done) b.offset_valid <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (b.mic_data_valid) corr[i] <= corr_n[i];
        if (b.offset_trigger || cal_done) cal_acc[i] <= '0;
        else if (cal_en) cal_acc[i] <= cal_sum[i];
        if (cal_done) b.offset_out[i*WIDTH +: WIDTH] <= cal_off[i];
`ifdef AUDIO_FRONTEND_DC_TRACK_EN
        else if (state == RUN && b.mic_data_valid) b.offset_out[i*WIDTH +: WIDTH] <= WIDTH'(trk[i]);
`endif
        if (c_valid) begin
          dec_acc[i] <= d_wrap ? '0 : dec_sum[i];
          if (d_wrap) b.processed_audio[i*WIDTH +: WIDTH] <= avg[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_frontend_mc.sv
// tb_audio_frontend_mc: directed stimulus with queued expected outputs, checked by a concurrent monitor
module tb_audio_frontend_mc;
  typedef struct {
    logic [31:0] d;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q[$];
  audio_frontend_mc_if #(.WIDTH(16), .NUM_CH(2)) b ();
  audio_frontend_mc #(.WIDTH(16), .NUM_CH(2), .CAL_LOG2(2), .DECIM_LOG2(1), .TRACK_SHIFT(2)) dut (
    .audio_clk(clk),
    .rst_in(rst),
    .b(b.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic t, input logic v, input int a0, input int a1,
                      input logic e, input int e0, input int e1);
    @(posedge clk);
    #1;
    b.offset_trigger = t;
    b.mic_data_valid = v;
    b.audio_in = {a1[15:0], a0[15:0]};
    if (e) q.push_back('{d: {e1[15:0], e0[15:0]}, c: cyc + 2});
  endtask
  task automatic idle();
    send(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask
  function automatic logic [31:0] pk(input int c0, input int c1);
    return {c1[15:0], c0[15:0]};
  endfunction
  initial begin
    b.offset_trigger = 1'b0;
    b.mic_data_valid = 1'b0;
    b.audio_in = '0;
    fork
      forever begin
        @(negedge clk);
        if (b.processed_valid) begin
          if (q.size() == 0) check("unexpected_strobe", {32'd0, b.processed_audio}, 64'hDEAD);
          else begin
            exp_t e;
            e = q.pop_front();
            check("processed_audio", {32'd0, b.processed_audio}, {32'd0, e.d});
            check("strobe_cycle", 64'(cyc), 64'(e.c));
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_processed_audio", {32'd0, b.processed_audio}, 64'd0);
    check("rst_offset_out", {32'd0, b.offset_out}, 64'd0);
    check("rst_offset_valid", {63'd0, b.offset_valid}, 64'd0);
    check("rst_cal_busy", {63'd0, b.cal_busy}, 64'd0);
    check("rst_processed_valid", {63'd0, b.processed_valid}, 64'd0);
`ifdef AUDIO_FRONTEND_DC_TRACK_EN
    send(1, 0, 0, 0, 0, 0, 0);
    send(0, 1, 100, 0, 0, 0, 0);
    send(0, 1, 100, 0, 1, 100, 0);
    send(0, 1, 100, 0, 0, 0, 0);
    send(0, 1, 100, 0, 1, 100, 0);
    send(0, 1, 200, 0, 0, 0, 0);
    check("trk_cal", {32'd0, b.offset_out}, {32'd0, pk(100, 0)});
    send(0, 1, 200, 0, 1, 87, 0);
    check("trk_step1", {32'd0, b.offset_out}, {32'd0, pk(125, 0)});
    send(0, 1, 200, 0, 0, 0, 0);
    check("trk_step2", {32'd0, b.offset_out}, {32'd0, pk(143, 0)});
    send(0, 1, 200, 0, 1, 50, 0);
    check("trk_step3", {32'd0, b.offset_out}, {32'd0, pk(157, 0)});
    idle();
    check("trk_step4", {32'd0, b.offset_out}, {32'd0, pk(167, 0)});
`else
    send(1, 0, 0, 0, 0, 0, 0);
    send(0, 1, 100, -5, 0, 0, 0);
    check("cal_busy_high", {63'd0, b.cal_busy}, 64'd1);
    check("offset_valid_pre", {63'd0, b.offset_valid}, 64'd0);
    send(0, 1, 102, -6, 1, 101, -6);
    send(0, 1, 98, -7, 0, 0, 0);
    send(0, 1, 100, -6, 1, 99, -7);
    idle();
    check("cal_offset", {32'd0, b.offset_out}, {32'd0, pk(100, -6)});
    check("cal_offset_valid", {63'd0, b.offset_valid}, 64'd1);
    check("cal_busy_low", {63'd0, b.cal_busy}, 64'd0);
    send(0, 1, 200, -6, 0, 0, 0);
    send(0, 1, 202, -4, 1, 101, 1);
    idle();
    send(1, 0, 0, 0, 0, 0, 0);
    send(0, 1, 100, -1000, 0, 0, 0);
    send(0, 1, 100, -1000, 1, 0, -994);
    send(0, 1, 100, -1000, 0, 0, 0);
    send(0, 1, 100, -1000, 1, 0, -994);
    send(0, 1, 99, 32767, 0, 0, 0);
    check("sat_cal_offset", {32'd0, b.offset_out}, {32'd0, pk(100, -1000)});
    send(0, 1, 98, 32767, 1, -2, 32767);
    idle();
    send(1, 0, 0, 0, 0, 0, 0);
    send(0, 1, 0, 0, 0, 0, 0);
    send(0, 1, 0, 0, 1, -100, 1000);
    send(1, 0, 0, 0, 0, 0, 0);
    send(1, 1, 999, 999, 0, 0, 0);
    check("restart_busy", {63'd0, b.cal_busy}, 64'd1);
    check("restart_old_offset", {32'd0, b.offset_out}, {32'd0, pk(100, -1000)});
    send(0, 1, 10, -2, 1, 404, 1498);
    send(0, 1, 20, -2, 0, 0, 0);
    send(0, 1, 30, -2, 1, -75, 998);
    send(0, 1, 40, -3, 0, 0, 0);
    check("restart_hold_busy", {63'd0, b.cal_busy}, 64'd1);
    check("restart_hold_offset", {32'd0, b.offset_out}, {32'd0, pk(100, -1000)});
    send(0, 1, 25, -3, 1, -30, 498);
    check("restart_new_offset", {32'd0, b.offset_out}, {32'd0, pk(25, -3)});
    check("restart_busy_low", {63'd0, b.cal_busy}, 64'd0);
    idle();
    send(1, 0, 0, 0, 0, 0, 0);
    send(0, 1, 5, 5, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    b.offset_trigger = 1'b0;
    b.mic_data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_processed_audio", {32'd0, b.processed_audio}, 64'd0);
    check("mid_rst_offset_out", {32'd0, b.offset_out}, 64'd0);
    check("mid_rst_offset_valid", {63'd0, b.offset_valid}, 64'd0);
    check("mid_rst_cal_busy", {63'd0, b.cal_busy}, 64'd0);
    send(0, 1, 7, -3, 0, 0, 0);
    send(0, 1, 8, -4, 1, 7, -4);
    idle();
`endif
    repeat (5) idle();
    check("queue_drained", 64'(q.size()), 64'd0);
`ifndef AUDIO_FRONTEND_DC_TRACK_EN
    check("processed_hold", {32'd0, b.processed_audio}, {32'd0, pk(7, -4)});
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
